// File: rtl/fifo_reader.sv
// Pulls words from a registered-flag FIFO into a 2-entry output buffer feeding a valid/ready stream.
// Read data lands one cycle after fifo_rd_en; reads stop whenever buffer + in-flight would exceed 2.
module fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] entry0, entry1;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic                  issue;
  logic [1:0]            slots_used;

  assign m_valid = (occ != 2'd0);
  assign m_data  = entry0;
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE);

  // Slots committed after this edge; a pop this cycle frees its entry for a new read.
  assign slots_used = occ + {1'b0, inflight} - {1'b0, pop};
  assign issue      = (state == ACTIVE) && enable && !fifo_empty && (slots_used < 2'd2);

  assign fifo_rd_en = issue;
  assign fifo_cs    = rst && (enable || busy);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_nxt = (m_valid || inflight) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)                     state_nxt = ACTIVE;
        else if (!m_valid && !inflight) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      occ      <= 2'd0;
      entry0   <= '0;
      entry1   <= '0;
      rd_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (inflight) rd_count <= rd_count + 1'b1;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) entry0 <= fifo_rdata;
          else             entry1 <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            entry0 <= entry1;
            entry1 <= fifo_rdata;
          end else begin
            entry0 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
